bcd_timer_ctrl: RTL
===================

Name: bcd_timer_ctrl

Overview:
Sequencing controller for a cascaded chain of synchronous decade (BCD) counter stages. The stages have a sync active-high clear, sync load, ENP/ENT enables and an RCO ripple output. The block drives the chain's clear, load and count-enable pins, prescales the system clock into count ticks, and compares the chain value against a programmed target. On a match it stops the chain (one-shot) or reloads it (auto-reload). It sits between the command/register logic and the counter datapath.

Parameters:
DIGITS, 2, number of BCD stages in the chain; all BCD buses are 4*DIGITS bits.
PRESCALE, 10, CLK cycles per count tick; legal range 2..65535.

Ports:
CLK  in  1  system clock, rising edge.
CLR_N  in  1  asynchronous active-low reset.
CMD_CLEAR  in  1  level; clear chain, go IDLE.
CMD_LOAD  in  1  level; load PRE_VAL into chain, go IDLE.
CMD_START  in  1  level; start or resume counting.
CMD_STOP  in  1  level; pause counting.
AUTO_RELOAD  in  1  1 = reload PRE_VAL on match, 0 = one-shot.
PRE_VAL  in  4*DIGITS  BCD preset value.
TARGET  in  4*DIGITS  BCD terminal value.
Q_IN  in  4*DIGITS  current chain value, from the counter Q outputs.
CNT_CLR  out  1  to chain CLR; one-cycle pulse.
CNT_LD  out  1  to chain LD; one-cycle pulse.
CNT_D  out  4*DIGITS  to chain D; valid while CNT_LD = 1.
CNT_ENP  out  1  to first-stage ENP; one-cycle tick pulse.
CNT_ENT  out  1  to first-stage ENT; high in RUN only.
MATCH  out  1  one-cycle pulse on each target match.
DONE  out  1  high while in DONE.
CFG_ERR  out  1  combinational configuration error flag.
STATE  out  3  IDLE=0, RUN=1, PAUSE=2, RELOAD=3, DONE=4.

Behaviour:
- All outputs are registered except CFG_ERR.
- CLR_N low, asynchronously and at any point including mid-RUN: STATE=IDLE, prescaler=0, every registered output=0 (CNT_D=0).
- CFG_ERR=1 when any of the following holds:
  - any 4-bit digit of PRE_VAL or TARGET is greater than 9;
  - AUTO_RELOAD=1 and PRE_VAL==TARGET.
- Command priority per cycle: CMD_CLEAR > CMD_LOAD > CMD_STOP > CMD_START. Commands are evaluated in every state.
- CMD_CLEAR: CNT_CLR=1 for the next cycle; STATE->IDLE; prescaler=0.
- CMD_LOAD: CNT_LD=1 and CNT_D=PRE_VAL for the next cycle; STATE->IDLE; prescaler=0.
- CMD_START:
  - ignored while CFG_ERR=1.
  - From IDLE or DONE: ->RUN with prescaler=0.
  - From PAUSE: ->RUN with the prescaler value kept.
  - Ignored in RUN and RELOAD.
- CMD_STOP: RUN->PAUSE with the prescaler held. Ignored in all other states.
- RUN:
  - CNT_ENT=1.
  - The prescaler counts 0..PRESCALE-1 and wraps.
  - When the prescaler equals PRESCALE-1, CNT_ENP=1 in the next cycle (exactly one cycle).
  - Match check runs every RUN cycle and has priority over the tick; on a match cycle no CNT_ENP is issued.
- Match (Q_IN==TARGET while in RUN):
  - MATCH=1 in the next cycle.
  - AUTO_RELOAD=0: ->DONE (DONE=1, CNT_ENT=0).
  - AUTO_RELOAD=1: ->RELOAD with CNT_LD=1 and CNT_D=PRE_VAL for that cycle, prescaler=0.
- RELOAD: exactly one cycle; match check is suppressed; then ->RUN.
- Latency: the chain increments on the edge that ends a CNT_ENP cycle. If that increment makes Q_IN==TARGET, MATCH and DONE assert 2 cycles after that CNT_ENP cycle.
- Start at target: if Q_IN==TARGET when RUN is entered (including START from DONE without a reload), the block spends one RUN cycle, then takes the match. The chain is never over-counted.
- PAUSE and IDLE: CNT_ENP=0 and CNT_ENT=0; Q_IN is not compared.
- Wrap: a TARGET the chain passes through is still matched at the first equality. A chain at all-9s wraps to 0 under its own ENT/RCO rules; the controller takes no special action.

Test Plan:
1. Reset release, DIGITS=2, PRESCALE=10, no commands -> STATE=0 and all outputs 0. Assert CLR_N low mid-RUN -> outputs 0 immediately, no clock needed.
2. CMD_LOAD with PRE_VAL=8'h05, then START with TARGET=8'h08, AUTO_RELOAD=0 -> CNT_LD pulses with CNT_D=05. Three CNT_ENP pulses are exactly 10 cycles apart. MATCH, and DONE=1 with STATE=4, follow 2 cycles after the 3rd pulse. No 4th pulse.
3. AUTO_RELOAD=1, PRE_VAL=8'h00, TARGET=8'h02 -> MATCH every 2 ticks. Each match gives a one-cycle RELOAD (STATE=3) with CNT_LD=1 and CNT_D=00, then RUN again.
4. STOP after 4 prescaler cycles, hold in PAUSE for 20 cycles, then START -> next CNT_ENP arrives 6 cycles into RUN. No CNT_ENP or CNT_ENT during PAUSE.
5. CMD_CLEAR, CMD_LOAD and CMD_START asserted in the same cycle -> only CNT_CLR pulses, STATE=IDLE.
6. TARGET=8'h1A, or AUTO_RELOAD=1 with PRE_VAL==TARGET -> CFG_ERR=1 and START stays in IDLE. With TARGET=8'h09 and a chain wrapping 99->00 -> the match occurs at 09.

Source files
------------

// File: rtl/bcd_timer_ctrl.sv
// Sequencing controller for a cascaded BCD counter chain.
// Drives the chain's clear/load/enable pins, prescales CLK into count ticks,
// and compares the chain value against a target (one-shot or auto-reload).
module bcd_timer_ctrl #(
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned PRESCALE = 10
) (
    input  logic                  CLK,
    input  logic                  CLR_N,
    input  logic                  CMD_CLEAR,
    input  logic                  CMD_LOAD,
    input  logic                  CMD_START,
    input  logic                  CMD_STOP,
    input  logic                  AUTO_RELOAD,
    input  logic [4*DIGITS-1:0]   PRE_VAL,
    input  logic [4*DIGITS-1:0]   TARGET,
    input  logic [4*DIGITS-1:0]   Q_IN,
    output logic                  CNT_CLR,
    output logic                  CNT_LD,
    output logic [4*DIGITS-1:0]   CNT_D,
    output logic                  CNT_ENP,
    output logic                  CNT_ENT,
    output logic                  MATCH,
    output logic                  DONE,
    output logic                  CFG_ERR,
    output logic [2:0]            STATE
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRun    = 3'd1,
        StPause  = 3'd2,
        StReload = 3'd3,
        StDone   = 3'd4
    } state_e;

    // Prescaler is sized for the largest legal PRESCALE (65535).
    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

    state_e                state_q;
    logic [15:0]           presc_q;
    logic                  cnt_clr_q;
    logic                  cnt_ld_q;
    logic [4*DIGITS-1:0]   cnt_d_q;
    logic                  cnt_enp_q;
    logic                  cnt_ent_q;
    logic                  match_q;
    logic                  done_q;

    logic                  digit_err;
    logic                  start_ok;
    logic                  at_target;
    logic                  presc_last;

    // Flag any preset or target digit outside 0..9.
    always_comb begin
        digit_err = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if ((PRE_VAL[4*i +: 4] > 4'd9) || (TARGET[4*i +: 4] > 4'd9)) begin
                digit_err = 1'b1;
            end
        end
    end

    // Auto-reload with preset == target would match forever without counting.
    assign CFG_ERR = digit_err | (AUTO_RELOAD & (PRE_VAL == TARGET));

    // STOP outranks START, so a simultaneous STOP blocks a start in any state.
    assign start_ok   = CMD_START & ~CMD_STOP & ~CFG_ERR;
    assign at_target  = (Q_IN == TARGET);
    assign presc_last = (presc_q == PRESC_MAX);

    // Controller FSM with prescaler and registered chain-control outputs.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q   <= StIdle;
            presc_q   <= '0;
            cnt_clr_q <= 1'b0;
            cnt_ld_q  <= 1'b0;
            cnt_d_q   <= '0;
            cnt_enp_q <= 1'b0;
            cnt_ent_q <= 1'b0;
            match_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            cnt_clr_q <= 1'b0;
            cnt_ld_q  <= 1'b0;
            cnt_d_q   <= '0;
            cnt_enp_q <= 1'b0;
            match_q   <= 1'b0;

            if (CMD_CLEAR) begin
                state_q   <= StIdle;
                presc_q   <= '0;
                cnt_clr_q <= 1'b1;
                cnt_ent_q <= 1'b0;
                done_q    <= 1'b0;
            end else if (CMD_LOAD) begin
                state_q   <= StIdle;
                presc_q   <= '0;
                cnt_ld_q  <= 1'b1;
                cnt_d_q   <= PRE_VAL;
                cnt_ent_q <= 1'b0;
                done_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle, StDone: begin
                        if (start_ok) begin
                            state_q   <= StRun;
                            presc_q   <= '0;
                            cnt_ent_q <= 1'b1;
                            done_q    <= 1'b0;
                        end
                    end

                    StPause: begin
                        // Resume keeps the prescaler phase.
                        if (start_ok) begin
                            state_q   <= StRun;
                            cnt_ent_q <= 1'b1;
                        end
                    end

                    StRun: begin
                        if (CMD_STOP) begin
                            state_q   <= StPause;
                            cnt_ent_q <= 1'b0;
                        end else if (at_target) begin
                            // Match wins over a tick so the chain is never over-counted.
                            match_q   <= 1'b1;
                            cnt_ent_q <= 1'b0;
                            if (AUTO_RELOAD) begin
                                state_q  <= StReload;
                                cnt_ld_q <= 1'b1;
                                cnt_d_q  <= PRE_VAL;
                                presc_q  <= '0;
                            end else begin
                                state_q <= StDone;
                                done_q  <= 1'b1;
                            end
                        end else if (presc_last) begin
                            presc_q   <= '0;
                            cnt_enp_q <= 1'b1;
                        end else begin
                            presc_q <= presc_q + 16'd1;
                        end
                    end

                    StReload: begin
                        // Single cycle while the chain takes the preset; no compare.
                        state_q   <= StRun;
                        cnt_ent_q <= 1'b1;
                    end

                    default: begin
                        state_q   <= StIdle;
                        presc_q   <= '0;
                        cnt_ent_q <= 1'b0;
                        done_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign CNT_CLR = cnt_clr_q;
    assign CNT_LD  = cnt_ld_q;
    assign CNT_D   = cnt_d_q;
    assign CNT_ENP = cnt_enp_q;
    assign CNT_ENT = cnt_ent_q;
    assign MATCH   = match_q;
    assign DONE    = done_q;
    assign STATE   = state_q;

endmodule
